ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  decoder bundle on ex_in/mem_in is a real instruction.
REQ-004 ex_in  input  5  EX bundle {aluop[2:0], memread, memwrite}.
REQ-005 mem_in  input  7  MEM bundle {regwrite, memtoreg, pctoreg, jump, jumpmem, branchn, branchz}.
REQ-006 stall  input  1  hold ID/EX stage and upstream; insert bubble downstream.
REQ-007 alu_n, alu_z  input  1 each  ALU negative/zero flags of the instruction currently in EX.
REQ-008 ex_aluop  output  3  ALU operation of the EX-stage instruction (0 when bubble).
REQ-009 ex_memread, ex_memwrite  output  1 each  memory strobes, gated by EX-stage valid.
REQ-010 mem_jump, mem_jumpmem  output  1 each  jump-source selects of the MEM-stage instruction, gated by valid.
REQ-011 redirect  output  1  PC redirect taken this cycle.
REQ-012 wb_regwrite, wb_memtoreg, wb_pctoreg  output  1 each  writeback controls, gated by WB valid.
REQ-013 squash_cnt  output  8  saturating count of instructions squashed since reset.

Function
REQ-014 Three register stages SHALL exist: IDEX (valid, ex, mem), EXMEM (valid, mem, n, z), MEMWB (valid, regwrite, memtoreg, pctoreg).
REQ-015 Instruction accepted into IDEX when in_valid=1, stall=0, state=RUN, redirect=0; otherwise IDEX loads bubble, except when stall=1 (and redirect=0), when IDEX holds.
REQ-016 EXMEM SHALL load IDEX contents plus alu_n/alu_z each cycle; if stall=1 it loads a bubble (valid=0).
REQ-017 MEMWB SHALL load EXMEM contents every cycle; never stalled.
REQ-018 redirect = EXMEM.valid & (jump | jumpmem | (branchn & n) | (branchz & z)); combinational from EXMEM registers.
REQ-019 Latency: bundle accepted at edge k appears on ex_* after edge k, mem_* and redirect after edge k+1, wb_* after edge k+2.
REQ-020 FSM states RUN, SQUASH. RUN -> SQUASH when redirect=1; SQUASH -> RUN unconditionally next cycle.
REQ-021 When redirect=1: IDEX and EXMEM SHALL load bubbles (squash the two younger instructions); incoming in_valid ignored.
REQ-022 In SQUASH: incoming in_valid ignored (IDEX loads bubble); this discards the wrong-path fetch.
REQ-023 squash_cnt SHALL increment by number of valid instructions discarded per cycle (IDEX.valid + in_valid on redirect; in_valid in SQUASH), saturating at 255.
REQ-024 redirect and stall simultaneous: redirect wins; no hold occurs.
REQ-025 Bubble stages SHALL drive all gated outputs to 0; ex_aluop SHALL be 0 for bubbles.
REQ-026 Opcode with no meaningful bundle (all-zero ex_in/mem_in) SHALL flow as valid no-op.

Reset
REQ-027 On rst=1 at a clock edge: all stage valids 0, all stored bundles 0, state RUN, squash_cnt 0.
REQ-028 All outputs SHALL read 0 in the cycle following a reset edge.
REQ-029 Reset mid-operation SHALL discard in-flight instructions with no squash_cnt increment; rst overrides stall and redirect.

Structure
REQ-030 Shared package SHALL hold bit-position constants for EX/MEM bundle fields, bundle widths (5, 7), and FSM state encoding.
REQ-031 One sub-module, ctrl_stage_reg (parameterised width, load/hold/bubble control), SHALL implement each stage register.

Verification
REQ-032 Reset then in_valid=1, ex_in=5'b01100, mem_in=7'b1000000 -> ex_aluop=3'b011 after 1 edge; wb_regwrite=1 after 3 edges.
REQ-033 Jump: mem_in=7'b0001000 followed by two valid bundles -> redirect=1 two edges after accept; both younger bundles never reach wb; squash_cnt=2.
REQ-034 Branch-Z not taken: mem_in=7'b0000001 with alu_z=0 -> redirect=0, following instruction completes; with alu_z=1 -> redirect=1.
REQ-035 stall=1 for 2 cycles with valid in IDEX -> ex outputs held, two bubbles in EXMEM (mem_jump=0, wb_regwrite=0 in those slots).
REQ-036 redirect coincident with stall=1 -> IDEX flushed, state SQUASH, no hold; rst asserted in SQUASH -> all outputs 0, squash_cnt 0.
REQ-037 256+ squashes -> squash_cnt holds 255.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the ctrl_pipe control pipeline: bundle layouts,
// stage widths, FSM encoding and the saturating squash counter helper.
package ctrl_pipe_pkg;

  localparam int unsigned EX_W  = 5;
  localparam int unsigned MEM_W = 7;

  // EX bundle {aluop[2:0], memread, memwrite}
  localparam int unsigned EX_ALUOP_LSB = 2;
  localparam int unsigned EX_ALUOP_W   = 3;
  localparam int unsigned EX_MEMREAD   = 1;
  localparam int unsigned EX_MEMWRITE  = 0;

  // MEM bundle {regwrite, memtoreg, pctoreg, jump, jumpmem, branchn, branchz}
  localparam int unsigned MEM_REGWRITE = 6;
  localparam int unsigned MEM_MEMTOREG = 5;
  localparam int unsigned MEM_PCTOREG  = 4;
  localparam int unsigned MEM_JUMP     = 3;
  localparam int unsigned MEM_JUMPMEM  = 2;
  localparam int unsigned MEM_BRANCHN  = 1;
  localparam int unsigned MEM_BRANCHZ  = 0;

  localparam int unsigned IDEX_W  = 1 + EX_W + MEM_W;
  localparam int unsigned EXMEM_W = 1 + MEM_W + 2;
  localparam int unsigned MEMWB_W = 4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-side inputs and pipeline control outputs of ctrl_pipe.
interface ctrl_pipe_if;
  import ctrl_pipe_pkg::*;

  logic             in_valid;
  logic [EX_W-1:0]  ex_in;
  logic [MEM_W-1:0] mem_in;
  logic             stall;
  logic             alu_n;
  logic             alu_z;
  logic [2:0]       ex_aluop;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             mem_jump;
  logic             mem_jumpmem;
  logic             redirect;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic             wb_pctoreg;
  logic [7:0]       squash_cnt;

  modport master (
    output in_valid, ex_in, mem_in, stall, alu_n, alu_z,
    input  ex_aluop, ex_memread, ex_memwrite, mem_jump, mem_jumpmem,
           redirect, wb_regwrite, wb_memtoreg, wb_pctoreg, squash_cnt
  );

  modport slave (
    input  in_valid, ex_in, mem_in, stall, alu_n, alu_z,
    output ex_aluop, ex_memread, ex_memwrite, mem_jump, mem_jumpmem,
           redirect, wb_regwrite, wb_memtoreg, wb_pctoreg, squash_cnt
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register: reset/bubble clear to zero, load takes d_i, else hold.
module ctrl_stage_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) q_q <= '0;
    else if (load_i)     q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/ctrl_pipe.sv
// Three-stage control pipeline (ID/EX, EX/MEM, MEM/WB) with stall hold,
// redirect-driven squash of younger instructions and a saturating squash counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_q;
  logic [MEMWB_W-1:0] memwb_q;
  state_e             state_q;
  logic [7:0]         squash_cnt_q;

  logic             idex_v, em_v, em_n, em_z, wb_v;
  logic [EX_W-1:0]  idex_ex;
  logic [MEM_W-1:0] idex_mem, em_mem;
  logic             redirect, accept;
  logic [1:0]       squash_inc;

  assign idex_v   = idex_q[IDEX_W-1];
  assign idex_ex  = idex_q[MEM_W +: EX_W];
  assign idex_mem = idex_q[0 +: MEM_W];
  assign em_v     = exmem_q[EXMEM_W-1];
  assign em_mem   = exmem_q[2 +: MEM_W];
  assign em_n     = exmem_q[1];
  assign em_z     = exmem_q[0];
  assign wb_v     = memwb_q[3];

  assign redirect = em_v & (em_mem[MEM_JUMP] | em_mem[MEM_JUMPMEM] |
                            (em_mem[MEM_BRANCHN] & em_n) | (em_mem[MEM_BRANCHZ] & em_z));
  assign accept   = bus.in_valid & ~bus.stall & (state_q == ST_RUN) & ~redirect;

  // Redirect dominates stall: IDEX only holds when stalled without a redirect.
  ctrl_stage_reg #(.WIDTH(IDEX_W)) u_idex (
    .clk(clk), .rst(rst),
    .load_i(accept),
    .bubble_i(redirect | (~bus.stall & ~accept)),
    .d_i({1'b1, bus.ex_in, bus.mem_in}),
    .q_o(idex_q)
  );

  ctrl_stage_reg #(.WIDTH(EXMEM_W)) u_exmem (
    .clk(clk), .rst(rst),
    .load_i(1'b1),
    .bubble_i(redirect | bus.stall),
    .d_i({idex_v, idex_mem, bus.alu_n, bus.alu_z}),
    .q_o(exmem_q)
  );

  ctrl_stage_reg #(.WIDTH(MEMWB_W)) u_memwb (
    .clk(clk), .rst(rst),
    .load_i(1'b1),
    .bubble_i(1'b0),
    .d_i({em_v, em_mem[MEM_REGWRITE], em_mem[MEM_MEMTOREG], em_mem[MEM_PCTOREG]}),
    .q_o(memwb_q)
  );

  always_comb begin
    squash_inc = '0;
    if (redirect)                  squash_inc = {1'b0, idex_v} + {1'b0, bus.in_valid};
    else if (state_q == ST_SQUASH) squash_inc = {1'b0, bus.in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      squash_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN:    if (redirect) state_q <= ST_SQUASH;
        ST_SQUASH: state_q <= ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
      squash_cnt_q <= sat_add8(squash_cnt_q, squash_inc);
    end
  end

  assign bus.ex_aluop    = idex_v ? idex_ex[EX_ALUOP_LSB +: EX_ALUOP_W] : '0;
  assign bus.ex_memread  = idex_v & idex_ex[EX_MEMREAD];
  assign bus.ex_memwrite = idex_v & idex_ex[EX_MEMWRITE];
  assign bus.mem_jump    = em_v & em_mem[MEM_JUMP];
  assign bus.mem_jumpmem = em_v & em_mem[MEM_JUMPMEM];
  assign bus.redirect    = redirect;
  assign bus.wb_regwrite = wb_v & memwb_q[2];
  assign bus.wb_memtoreg = wb_v & memwb_q[1];
  assign bus.wb_pctoreg  = wb_v & memwb_q[0];
  assign bus.squash_cnt  = squash_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic
// compared every cycle against an instruction-slot reference model.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  ctrl_pipe_if bus();
  ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] ex;
    logic [6:0] mem;
    logic       n;
    logic       z;
  } slot_t;

  slot_t m_id, m_em, m_wb;
  bit    m_sq;
  int    m_cnt;

  function automatic bit m_redirect();
    return m_em.v && (m_em.mem[3] || m_em.mem[2] ||
                      (m_em.mem[1] && m_em.n) || (m_em.mem[0] && m_em.z));
  endfunction

  function automatic logic [18:0] exp_outs();
    logic [2:0] op;
    logic [7:0] c;
    op = m_id.v ? m_id.ex[4:2] : 3'd0;
    c  = 8'(m_cnt);
    return {op, m_id.v & m_id.ex[1], m_id.v & m_id.ex[0],
            m_em.v & m_em.mem[3], m_em.v & m_em.mem[2], 1'(m_redirect()),
            m_wb.v & m_wb.mem[6], m_wb.v & m_wb.mem[5], m_wb.v & m_wb.mem[4], c};
  endfunction

  function automatic logic [18:0] act_outs();
    return {bus.ex_aluop, bus.ex_memread, bus.ex_memwrite, bus.mem_jump, bus.mem_jumpmem,
            bus.redirect, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_pctoreg, bus.squash_cnt};
  endfunction

  // Advance the reference by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit rd;
    int lost;
    rd = m_redirect();
    lost = 0;
    if (rst) begin
      m_id = '0; m_em = '0; m_wb = '0; m_sq = 0; m_cnt = 0;
      return;
    end
    m_wb = m_em;
    if (rd || bus.stall) m_em = '0;
    else begin
      m_em = m_id;
      m_em.n = bus.alu_n;
      m_em.z = bus.alu_z;
    end
    if (rd) begin
      lost = int'(m_id.v) + int'(bus.in_valid);
      m_id = '0;
    end else if (m_sq) begin
      lost = int'(bus.in_valid);
      if (!bus.stall) m_id = '0;
    end else if (!bus.stall) begin
      m_id = bus.in_valid ? {1'b1, bus.ex_in, bus.mem_in, 2'b00} : '0;
    end
    m_sq = rd;
    m_cnt = (m_cnt + lost > 255) ? 255 : m_cnt + lost;
  endtask

  task automatic step();
    logic [18:0] e, a;
    @(posedge clk);
    model_step();
    #1;
    e = exp_outs();
    a = act_outs();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outputs @%0t: got %05h expected %05h", $time, a, e);
    end
  endtask

  task automatic drv(input logic iv, input logic [4:0] ex, input logic [6:0] mem,
                     input logic st, input logic n, input logic z);
    bus.in_valid = iv; bus.ex_in = ex; bus.mem_in = mem;
    bus.stall = st; bus.alu_n = n; bus.alu_z = z;
  endtask

  task automatic do_reset();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drv(1, 5'b11111, 7'b1111111, 0, 1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    n_tests++;
    if (act_outs() !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %05h expected 00000", act_outs());
    end
  endtask

  task automatic test_basic();
    do_reset();
    drv(1, 5'b01100, 7'b1000000, 0, 0, 0);
    step();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    n_tests++;
    if (bus.ex_aluop !== 3'b011) begin
      n_fail++;
      $display("FAIL basic_aluop: got %0d expected 3", bus.ex_aluop);
    end
    step();
    step();
    n_tests++;
    if (bus.wb_regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wb_regwrite: got %0b expected 1", bus.wb_regwrite);
    end
  endtask

  task automatic test_jump();
    do_reset();
    drv(1, 5'd0, 7'b0001000, 0, 0, 0);
    step();
    drv(1, 5'b00100, 7'b1000000, 0, 0, 0);
    step();
    n_tests++;
    if (bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_redirect: got %0b expected 1", bus.redirect);
    end
    step();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (bus.wb_regwrite !== 1'b0) begin
        n_fail++;
        $display("FAIL jump_squashed_wb[%0d]: got %0b expected 0", i, bus.wb_regwrite);
      end
    end
    n_tests++;
    if (bus.squash_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL jump_squash_cnt: got %0d expected 2", bus.squash_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drv(1, 5'd0, 7'b0000001, 0, 0, 0);
    step();
    drv(1, 5'd0, 7'b1000000, 0, 0, 0);
    step();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    n_tests++;
    if (bus.redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL branchz_not_taken: got %0b expected 0", bus.redirect);
    end
    step();
    step();
    n_tests++;
    if (bus.wb_regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL branchz_follower_wb: got %0b expected 1", bus.wb_regwrite);
    end
    do_reset();
    drv(1, 5'd0, 7'b0000001, 0, 0, 0);
    step();
    drv(0, 5'd0, 7'd0, 0, 0, 1);
    step();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    n_tests++;
    if (bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL branchz_taken: got %0b expected 1", bus.redirect);
    end
    step();
  endtask

  task automatic test_stall();
    do_reset();
    drv(1, 5'b10100, 7'b1001000, 0, 0, 0);
    step();
    drv(1, 5'b11111, 7'b0000000, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (bus.ex_aluop !== 3'd5 || bus.mem_jump !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got aluop=%0d jump=%0b expected aluop=5 jump=0",
                 i, bus.ex_aluop, bus.mem_jump);
      end
    end
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    step();
    n_tests++;
    if (bus.wb_regwrite !== 1'b0 || bus.mem_jump !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got wb=%0b jump=%0b expected wb=0 jump=1",
               bus.wb_regwrite, bus.mem_jump);
    end
    step();
    n_tests++;
    if (bus.wb_regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_wb: got %0b expected 1", bus.wb_regwrite);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    drv(1, 5'd0, 7'b0001000, 0, 0, 0);
    step();
    drv(1, 5'b11100, 7'b1000000, 0, 0, 0);
    step();
    drv(1, 5'b11100, 7'b1000000, 1, 0, 0);
    step();
    n_tests++;
    if (bus.ex_aluop !== 3'd0 || bus.squash_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL redirect_over_stall: got aluop=%0d cnt=%0d expected aluop=0 cnt=2",
               bus.ex_aluop, bus.squash_cnt);
    end
    drv(1, 5'b11100, 7'b1001000, 0, 1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    n_tests++;
    if (act_outs() !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_in_squash: got %05h expected 00000", act_outs());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drv(1, 5'd0, 7'b0001000, 0, 0, 0);
    for (int i = 0; i < 400; i++) step();
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    step();
    n_tests++;
    if (bus.squash_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL squash_saturate: got %0d expected 255", bus.squash_cnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] mem;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mem = 7'($urandom);
      if ($urandom_range(0, 3) != 0) mem[3:2] = 2'b00;
      drv(1'($urandom_range(0, 1)), 5'($urandom), mem,
          $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    drv(0, 5'd0, 7'd0, 0, 0, 0);
    m_id = '0; m_em = '0; m_wb = '0; m_sq = 0; m_cnt = 0;
    test_reset();
    test_basic();
    test_jump();
    test_branch();
    test_stall();
    test_redirect_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
